// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - functional-unit result handshake and register file write bundle for wb_queue
interface wb_queue_if #(
    parameter int N_FU     = 4,
    parameter int WB_WIDTH = 2,
    parameter int XLEN     = 64,
    parameter int DW       = 6
);
    logic [N_FU-1:0]                fu_valid;
    logic [N_FU-1:0]                fu_ready;
    logic [N_FU-1:0][DW-1:0]        fu_dst;
    logic [N_FU-1:0][XLEN-1:0]      fu_data;
    logic [WB_WIDTH-1:0]            wb_valid;
    logic [WB_WIDTH-1:0][DW-1:0]    wb_dst;
    logic [WB_WIDTH-1:0][XLEN-1:0]  wb_opd;

    modport master (
        output fu_valid, fu_dst, fu_data,
        input  fu_ready, wb_valid, wb_dst, wb_opd
    );

    modport slave (
        input  fu_valid, fu_dst, fu_data,
        output fu_ready, wb_valid, wb_dst, wb_opd
    );
endinterface

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback queue from functional units to register file write ports
// Optional same-cycle bypass when the queue is empty: define WB_BYPASS_EN.
module wb_queue #(
    parameter int N_FU     = 4,
    parameter int WB_WIDTH = 2,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 64,
    parameter int PREGS    = 64,
    parameter int DW       = $clog2(PREGS)
) (
    input  logic                        clock,
    input  logic                        reset,
    wb_queue_if.slave                   bus,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [DW-1:0]   mem_dst_q  [DEPTH];
    logic [DW-1:0]   mem_dst_d  [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [XLEN-1:0] mem_data_d [DEPTH];

    logic                           ready;
    logic [WB_WIDTH-1:0]            wb_valid;
    logic [WB_WIDTH-1:0][DW-1:0]    wb_dst;
    logic [WB_WIDTH-1:0][XLEN-1:0]  wb_opd;
    int                             n_enq;
    int                             drained;
`ifdef WB_BYPASS_EN
    int                             n_byp;
`endif

    always_comb begin
        // Ready depends only on registered occupancy so a full FU burst always fits.
        ready   = reset && (count_q <= CW'(DEPTH - N_FU));
        drained = (int'(count_q) > WB_WIDTH) ? WB_WIDTH : int'(count_q);

        wb_valid = '0;
        wb_dst   = '0;
        wb_opd   = '0;
        for (int k = 0; k < WB_WIDTH; k++) begin
            if (reset && int'(count_q) > k) begin
                wb_valid[k] = 1'b1;
                for (int e = 0; e < DEPTH; e++) begin
                    if (e == (int'(head_q) + k) % DEPTH) begin
                        wb_dst[k] = mem_dst_q[e];
                        wb_opd[k] = mem_data_q[e];
                    end
                end
            end
        end

        mem_dst_d  = mem_dst_q;
        mem_data_d = mem_data_q;
        n_enq      = 0;
`ifdef WB_BYPASS_EN
        n_byp      = 0;
`endif
        // Ascending FU index gives same-cycle arrivals their age order; x0 writes are dropped.
        for (int i = 0; i < N_FU; i++) begin
            if (bus.fu_valid[i] && ready && bus.fu_dst[i] != '0) begin
`ifdef WB_BYPASS_EN
                if (count_q == '0 && n_byp < WB_WIDTH) begin
                    for (int k = 0; k < WB_WIDTH; k++) begin
                        if (k == n_byp) begin
                            wb_valid[k] = 1'b1;
                            wb_dst[k]   = bus.fu_dst[i];
                            wb_opd[k]   = bus.fu_data[i];
                        end
                    end
                    n_byp++;
                end else
`endif
                begin
                    for (int e = 0; e < DEPTH; e++) begin
                        if (e == (int'(tail_q) + n_enq) % DEPTH) begin
                            mem_dst_d[e]  = bus.fu_dst[i];
                            mem_data_d[e] = bus.fu_data[i];
                        end
                    end
                    n_enq++;
                end
            end
        end

        count_d = CW'(int'(count_q) - drained + n_enq);
        head_d  = PW'((int'(head_q) + drained) % DEPTH);
        tail_d  = PW'((int'(tail_q) + n_enq) % DEPTH);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            mem_dst_q  <= '{default: '0};
            mem_data_q <= '{default: '0};
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_dst_q  <= mem_dst_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.fu_ready = {N_FU{ready}};
    assign bus.wb_valid = wb_valid;
    assign bus.wb_dst   = wb_dst;
    assign bus.wb_opd   = wb_opd;
    assign count        = count_q;
endmodule
